eeprom_cmd_seq: RTL

Command sequencer directly upstream of the EEPROM serial read/write controller. It accepts burst commands (start address, byte count, direction) from a host and breaks each burst into single-byte WR/RD transactions. For each byte it holds ADDR and DATA stable until the controller returns ACK, then advances to the next byte. Write bytes are taken from a host stream, and read bytes are returned on a host stream.

---
 rtl/eeprom_pkg.sv | 18 +
 rtl/eeprom_ack_timer.sv | 37 +++
 rtl/eeprom_cmd_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/eeprom_pkg.sv
// Shared constants and state encoding for the EEPROM command sequencer.
package eeprom_pkg;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_FETCH = 5'b00010,
      ST_ISSUE = 5'b00100,
      ST_GAP   = 5'b01000,
      ST_FIN   = 5'b10000
   } state_t;

endpackage

// File: rtl/eeprom_ack_timer.sv
// ACK watchdog: counts cycles spent waiting for the controller and flags the
// cycle whose closing edge completes 2^TO_W-1 cycles without an ACK.
module eeprom_ack_timer #(
   parameter int TO_W = 12
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_o
);

   // Count value seen in the (2^TO_W-1)-th enabled cycle
   localparam logic [TO_W-1:0] LAST = {{(TO_W-1){1'b1}}, 1'b0};

   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/eeprom_cmd_seq.sv
// Splits host burst commands into single-byte WR/RD handshakes with the
// EEPROM controller, streaming write bytes in and read bytes out.
module eeprom_cmd_seq
   import eeprom_pkg::*;
#(
   parameter int LEN_W      = 11,
   parameter int TO_W       = 12,
   parameter int GAP_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   input  logic [DATA_W-1:0] wdata,
   output logic              rdata_valid,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              WR,
   output logic              RD,
   output logic [ADDR_W-1:0] ADDR,
   inout  wire  [DATA_W-1:0] DATA,
   input  logic              ACK
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   state_t            state_q, state_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              wr_q, wr_d;
   logic              rd_q, rd_d;
   logic              oe_q, oe_d;
   logic              to_expire;

   eeprom_ack_timer #(.TO_W(TO_W)) u_timer (
      .CLK      (CLK),
      .RESET    (RESET),
      .clear_i  (state_q != ST_ISSUE),
      .en_i     (state_q == ST_ISSUE),
      .expire_o (to_expire)
   );

   always_comb begin
      state_d  = state_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      len_d    = len_q;
      data_d   = data_q;
      gap_d    = gap_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               rw_d    = cmd_rw;
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               err_d   = 1'b0;
               state_d = (cmd_rw == RW_WRITE) ? ST_FETCH : ST_ISSUE;
            end
         end
         ST_FETCH: begin
            if (wdata_valid) begin
               data_d  = wdata;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // ACK takes priority over a timeout landing in the same cycle
            if (ACK) begin
               if (rw_q == RW_READ) begin
                  rdata_d  = DATA;
                  rvalid_d = 1'b1;
               end
               if (len_q == '0) begin
                  state_d = ST_FIN;
               end else begin
                  len_d   = len_q - LEN_W'(1);
                  addr_d  = addr_q + ADDR_W'(1);
                  gap_d   = '0;
                  state_d = ST_GAP;
               end
            end else if (to_expire) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = (rw_q == RW_WRITE) ? ST_FETCH : ST_ISSUE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Requests and the bus enable are registered from the next state
      wr_d = (state_d == ST_ISSUE) && (rw_d == RW_WRITE);
      rd_d = (state_d == ST_ISSUE) && (rw_d == RW_READ);
      oe_d = wr_d;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         rw_q     <= RW_WRITE;
         addr_q   <= '0;
         len_q    <= '0;
         gap_q    <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         oe_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         gap_q    <= gap_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         oe_q     <= oe_d;
      end
   end

   // Write byte is only meaningful while oe_q is set, so it needs no reset
   always_ff @(posedge CLK) begin
      data_q <= data_d;
   end

   assign DATA        = oe_q ? data_q : {DATA_W{1'bz}};
   assign cmd_ready   = (state_q == ST_IDLE);
   assign wdata_ready = (state_q == ST_FETCH);
   assign busy        = (state_q != ST_IDLE) && (state_q != ST_FIN);
   assign done        = (state_q == ST_FIN);
   assign err         = err_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign WR          = wr_q;
   assign RD          = rd_q;
   assign ADDR        = addr_q;

endmodule
